display_scan_ctrl: RTL



---
 rtl/display_pkg.sv | 14 +
 rtl/scan_phase_counter.sv | 29 ++
 rtl/display_scan_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan path.
package display_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int SEL_W      = 3;
   localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      ON
   } scan_state_t;

endpackage

// File: rtl/scan_phase_counter.sv
// Loadable down-counter timing the BLANK and ON phases; o_tc flags the last cycle of a phase.
module scan_phase_counter
   import display_pkg::*;
#(
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_loadVal,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_count;

   // A phase of N cycles is loaded as N-1, so terminal count lands on its final cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_tc = (r_count == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scan controller: BLANK dead time then ON per digit slot.
// Optional per-digit PWM dimming is built when DISPLAY_SCAN_PWM_EN is defined.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int CNT_W        = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
`ifdef DISPLAY_SCAN_PWM_EN
   input  logic [3:0]            brightness,
`endif
   input  logic [NUM_DIGITS-1:0] digit_en,
   output logic [SEL_W-1:0]      sel,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  tick,
   output logic                  frame_done
);

   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);

   scan_state_t           r_state;
   scan_state_t           w_nextState;
   logic [SEL_W-1:0]      r_sel;
   logic [SEL_W-1:0]      w_nextSel;
   logic [NUM_DIGITS-1:0] r_an;
   logic [NUM_DIGITS-1:0] w_an;
   logic                  r_tick;
   logic                  w_tick;
   logic                  r_frameDone;
   logic                  w_frameDone;
   logic                  w_load;
   logic [CNT_W-1:0]      w_loadVal;
   logic                  w_tc;
   logic                  w_lit;

   scan_phase_counter #(
      .CNT_W (CNT_W)
   ) u_phaseCounter (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_loadVal (w_loadVal),
      .o_tc      (w_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_an        <= ANODES_OFF;
         r_tick      <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_sel       <= w_nextSel;
         r_an        <= w_an;
         r_tick      <= w_tick;
         r_frameDone <= w_frameDone;
      end
   end

   // Dropping en beats a slot end, so sel only advances while scanning stays enabled.
   always_comb begin
      w_nextState = r_state;
      w_nextSel   = r_sel;
      w_tick      = 1'b0;
      w_frameDone = 1'b0;
      w_load      = 1'b0;
      w_loadVal   = '0;
      case (r_state)
         IDLE: begin
            w_load = 1'b1;
            if (en) begin
               w_nextState = BLANK;
               w_loadVal   = BLANK_LOAD;
            end
         end
         BLANK: begin
            if (!en) begin
               w_nextState = IDLE;
               w_load      = 1'b1;
            end else if (w_tc) begin
               w_nextState = ON;
               w_load      = 1'b1;
               w_loadVal   = ON_LOAD;
            end
         end
         ON: begin
            if (!en) begin
               w_nextState = IDLE;
               w_load      = 1'b1;
            end else if (w_tc) begin
               w_nextState = BLANK;
               w_load      = 1'b1;
               w_loadVal   = BLANK_LOAD;
               w_nextSel   = r_sel + 1'b1;
               w_tick      = 1'b1;
               w_frameDone = (r_sel == SEL_W'(NUM_DIGITS - 1));
            end
         end
         default: begin
            w_nextState = IDLE;
            w_load      = 1'b1;
         end
      endcase
   end

`ifdef DISPLAY_SCAN_PWM_EN
   logic [3:0] r_pwmCnt;
   logic [3:0] w_nextPwm;

   // Counter restarts on every ON entry so each digit's duty window begins lit.
   assign w_nextPwm = (r_state == ON) ? r_pwmCnt + 1'b1 : 4'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pwmCnt <= 4'd0;
      end else begin
         r_pwmCnt <= w_nextPwm;
      end
   end

   assign w_lit = (w_nextState == ON) && digit_en[w_nextSel] && (w_nextPwm <= brightness);
`else
   assign w_lit = (w_nextState == ON) && digit_en[w_nextSel];
`endif

   // Anodes are decoded from the upcoming state and sel so they stay registered.
   assign w_an = w_lit ? ~(NUM_DIGITS'(1) << w_nextSel) : ANODES_OFF;

   assign sel        = r_sel;
   assign an         = r_an;
   assign tick       = r_tick;
   assign frame_done = r_frameDone;

endmodule
